// File: rtl/mac_rx_filter.sv
// rtl/mac_rx_filter.sv - Ethernet MAC receive filter: DA match, SA/EtherType capture, FCS strip, CRC and length check.
module mac_rx_filter #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  rx_data,
  input  logic [47:0] local_mac,
  input  logic        broadcast_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic [47:0] remote_mac,
  output logic [15:0] ethertype,
  output logic        frame_done,
  output logic        frame_good
);

  localparam logic [10:0] MIN_L       = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L       = 11'(MAX_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, DST, HDR, PAYLOAD, DISCARD} state_t;

  state_t      state, state_next;
  logic [10:0] cnt;
  logic [10:0] n;
  logic [31:0] crc, crc_seed, crc_next;
  logic [31:0] dly;
  logic        dst_match, dst_all_ff;
  logic [7:0]  mac_byte;
  logic        match_now, all_ff_now, accept;
  logic        consume, ending;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The byte presented in IDLE is byte 0; afterwards cnt holds its index.
  always_comb begin
    n = (state == IDLE) ? 11'd0 : cnt;
    case (n[2:0])
      3'd0:    mac_byte = local_mac[47:40];
      3'd1:    mac_byte = local_mac[39:32];
      3'd2:    mac_byte = local_mac[31:24];
      3'd3:    mac_byte = local_mac[23:16];
      3'd4:    mac_byte = local_mac[15:8];
      3'd5:    mac_byte = local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
    match_now  = (rx_data == mac_byte) && ((n == 11'd0) || dst_match);
    all_ff_now = (rx_data == 8'hFF) && ((n == 11'd0) || dst_all_ff);
    accept     = match_now || (all_ff_now && broadcast_en);
    crc_seed   = (state == IDLE) ? 32'hFFFFFFFF : crc;
    crc_next   = crc32_byte(crc_seed, rx_data);
    consume    = rx_enable && (state inside {IDLE, DST, HDR, PAYLOAD});
    ending     = !rx_enable && (state inside {HDR, PAYLOAD});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (!rx_enable) state_next = IDLE;
      IDLE:      if (rx_enable) state_next = DST;
      DST: begin
        if (!rx_enable)          state_next = IDLE;
        else if (n == 11'd5)     state_next = accept ? HDR : DISCARD;
      end
      HDR: begin
        if (!rx_enable)          state_next = IDLE;
        else if (n == 11'd13)    state_next = PAYLOAD;
      end
      PAYLOAD:   if (!rx_enable) state_next = IDLE;
      DISCARD:   if (!rx_enable) state_next = IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      crc        <= '0;
      dly        <= '0;
      dst_match  <= 1'b0;
      dst_all_ff <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      remote_mac <= '0;
      ethertype  <= '0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      if (consume) begin
        cnt        <= (n == 11'h7FF) ? n : n + 11'd1;
        crc        <= crc_next;
        dly        <= {dly[23:0], rx_data};
        dst_match  <= match_now;
        dst_all_ff <= all_ff_now;
        if (state == HDR && n <= 11'd11) remote_mac <= {remote_mac[39:0], rx_data};
        if (state == HDR && n >= 11'd12) ethertype  <= {ethertype[7:0], rx_data};
        // Releasing byte n-4 on arrival of byte n keeps the trailing FCS inside the delay line.
        if (state == PAYLOAD && n >= 11'd18) begin
          out_valid <= 1'b1;
          out_data  <= dly[31:24];
          out_sof   <= (n == 11'd18);
        end
      end
      if (ending) begin
        frame_done <= 1'b1;
        frame_good <= (crc == CRC_RESIDUE) && (cnt >= MIN_L) && (cnt <= MAX_L)
                      && (state == PAYLOAD) && (cnt > 11'd14);
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_filter.sv
// tb/tb_mac_rx_filter.sv - directed self-checking bench for mac_rx_filter.
`timescale 1ns/1ps
module tb_mac_rx_filter;

  localparam logic [47:0] LMAC = 48'h001CC0A213DD;
  localparam logic [47:0] SRC1 = 48'h020000ABCDEF;
  localparam logic [47:0] SRC2 = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_enable = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [47:0] local_mac = LMAC;
  logic        broadcast_en = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof;
  logic [47:0] remote_mac;
  logic [15:0] ethertype;
  logic        frame_done, frame_good;

  mac_rx_filter #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .rx_data(rx_data),
    .local_mac(local_mac), .broadcast_en(broadcast_en),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .remote_mac(remote_mac), .ethertype(ethertype),
    .frame_done(frame_done), .frame_good(frame_good)
  );

  always #5 clock = ~clock;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  logic [7:0] frm [0:2047];
  logic [7:0] exp_q[$], got_q[$];
  int sof_cnt, sof_at, sof_neg_cyc, done_cnt, good_cnt, done_overlap;
  logic last_good = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (out_sof) begin
      sof_cnt++;
      sof_at = got_q.size();
      sof_neg_cyc = cyc;
    end
    if (out_valid) got_q.push_back(out_data);
    if (frame_done) begin
      done_cnt++;
      if (frame_good) good_cnt++;
      last_good = frame_good;
      if (rx_enable) done_overlap++;
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build(input int len, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dst[47-8*i -: 8];
      frm[6 + i] = src[47-8*i -: 8];
    end
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    for (int i = 14; i < len - 4; i++) frm[i] = 8'((i * 13 + seed * 29) ^ (i >> 3));
    for (int i = 0; i < len - 4; i++) c = crc_upd(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm[len - 4 + i] = c[8*i +: 8];
  endtask

  task automatic expect_payload(input int len);
    for (int i = 14; i < len - 4; i++) exp_q.push_back(frm[i]);
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    sof_cnt = 0; sof_at = -1; sof_neg_cyc = 0;
    done_cnt = 0; good_cnt = 0; done_overlap = 0;
  endtask

  task automatic drive(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rx_enable = 1'b1;
      rx_data = frm[i];
      @(posedge clock); #1;
    end
    rx_enable = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int k);
    rx_enable = 1'b0;
    repeat (k) begin @(posedge clock); #1; end
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clock); #1;
    compared++;
    if ({out_data, out_valid, out_sof, frame_done, frame_good} !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_out: got %h want 000", {out_data, out_valid, out_sof, frame_done, frame_good});
    end
    compared++;
    if ({remote_mac, ethertype} !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_hdr: got %h want 0", {remote_mac, ethertype});
    end
    // Release reset while a valid frame is already in flight; it must be ignored.
    build(64, LMAC, SRC1, 16'h0800, 9);
    clear_mon();
    reset = 1'b0;
    drive(0, 63);
    idle(4);
    compared++;
    if (got_q.size() !== 0) begin
      mismatched++;
      $display("FAIL reset_partial_bytes: got %0d want 0", got_q.size());
    end
    compared++;
    if (done_cnt !== 0 || remote_mac !== 48'd0) begin
      mismatched++;
      $display("FAIL reset_partial_done: done %0d mac %h want 0 / 0", done_cnt, remote_mac);
    end
  endtask

  task automatic test_unicast();
    build(64, LMAC, SRC1, 16'h0800, 1);
    clear_mon();
    expect_payload(64);
    drive(0, 63);
    idle(3);
    compared++;
    if (got_q.size() !== 46) begin mismatched++; $display("FAIL uni_count: got %0d want 46", got_q.size()); end
    compared++;
    if (first_diff() !== -1) begin mismatched++; $display("FAIL uni_data: diff at %0d want -1", first_diff()); end
    compared++;
    if (sof_cnt !== 1 || sof_at !== 0) begin
      mismatched++; $display("FAIL uni_sof: count %0d at %0d want 1 at 0", sof_cnt, sof_at);
    end
    compared++;
    if (remote_mac !== SRC1 || ethertype !== 16'h0800) begin
      mismatched++; $display("FAIL uni_hdr: got %h/%h want %h/0800", remote_mac, ethertype, SRC1);
    end
    compared++;
    if (done_cnt !== 1 || last_good !== 1'b1) begin
      mismatched++; $display("FAIL uni_status: done %0d good %0b want 1 1", done_cnt, last_good);
    end
  endtask

  task automatic test_broadcast();
    build(64, BC, SRC2, 16'h0806, 2);
    broadcast_en = 1'b0;
    clear_mon();
    drive(0, 63);
    idle(3);
    compared++;
    if (got_q.size() !== 0 || done_cnt !== 0 || remote_mac !== SRC1) begin
      mismatched++;
      $display("FAIL bc_off: bytes %0d done %0d mac %h want 0 0 %h", got_q.size(), done_cnt, remote_mac, SRC1);
    end
    broadcast_en = 1'b1;
    clear_mon();
    expect_payload(64);
    drive(0, 63);
    idle(3);
    compared++;
    if (first_diff() !== -1) begin mismatched++; $display("FAIL bc_on_data: diff at %0d want -1", first_diff()); end
    compared++;
    if (done_cnt !== 1 || last_good !== 1'b1 || remote_mac !== SRC2 || ethertype !== 16'h0806) begin
      mismatched++;
      $display("FAIL bc_on_status: done %0d good %0b hdr %h/%h want 1 1 %h/0806",
               done_cnt, last_good, remote_mac, ethertype, SRC2);
    end
    // Last destination byte differs: filtered even with broadcast enabled.
    build(64, LMAC ^ 48'h1, SRC1, 16'h0800, 4);
    clear_mon();
    drive(0, 63);
    idle(3);
    compared++;
    if (got_q.size() !== 0 || done_cnt !== 0) begin
      mismatched++; $display("FAIL da_lastbyte: bytes %0d done %0d want 0 0", got_q.size(), done_cnt);
    end
  endtask

  task automatic test_bad_crc();
    build(100, LMAC, SRC1, 16'h0800, 3);
    frm[40] = frm[40] ^ 8'h10;
    clear_mon();
    expect_payload(100);
    drive(0, 99);
    idle(3);
    compared++;
    if (got_q.size() !== 82) begin mismatched++; $display("FAIL badcrc_count: got %0d want 82", got_q.size()); end
    compared++;
    if (first_diff() !== -1) begin mismatched++; $display("FAIL badcrc_data: diff at %0d want -1", first_diff()); end
    compared++;
    if (done_cnt !== 1 || last_good !== 1'b0) begin
      mismatched++; $display("FAIL badcrc_status: done %0d good %0b want 1 0", done_cnt, last_good);
    end
  endtask

  task automatic test_length();
    build(60, LMAC, SRC1, 16'h0800, 5);
    clear_mon();
    drive(0, 59);
    idle(3);
    compared++;
    if (got_q.size() !== 42 || done_cnt !== 1 || last_good !== 1'b0) begin
      mismatched++;
      $display("FAIL runt: bytes %0d done %0d good %0b want 42 1 0", got_q.size(), done_cnt, last_good);
    end
    build(1519, LMAC, SRC1, 16'h0800, 6);
    clear_mon();
    drive(0, 1518);
    idle(3);
    compared++;
    if (got_q.size() !== 1501 || done_cnt !== 1 || last_good !== 1'b0) begin
      mismatched++;
      $display("FAIL oversize: bytes %0d done %0d good %0b want 1501 1 0", got_q.size(), done_cnt, last_good);
    end
    build(1518, LMAC, SRC1, 16'h0800, 7);
    clear_mon();
    expect_payload(1518);
    drive(0, 1517);
    idle(3);
    compared++;
    if (first_diff() !== -1 || got_q.size() !== 1500) begin
      mismatched++; $display("FAIL max_data: diff at %0d bytes %0d want -1 1500", first_diff(), got_q.size());
    end
    compared++;
    if (done_cnt !== 1 || last_good !== 1'b1) begin
      mismatched++; $display("FAIL max_status: done %0d good %0b want 1 1", done_cnt, last_good);
    end
  endtask

  task automatic test_reset_mid();
    build(64, LMAC, SRC2, 16'h0800, 8);
    clear_mon();
    drive(0, 29);
    rx_enable = 1'b1;
    rx_data = frm[30];
    reset = 1'b1;
    #1;
    compared++;
    if ({out_valid, out_sof, out_data, remote_mac, ethertype, frame_done, frame_good} !== 76'd0) begin
      mismatched++;
      $display("FAIL midrst_clear: valid %0b data %h mac %h et %h want all 0", out_valid, out_data, remote_mac, ethertype);
    end
    clear_mon();
    @(posedge clock); #1;
    reset = 1'b0;
    drive(31, 63);
    idle(3);
    compared++;
    if (got_q.size() !== 0 || done_cnt !== 0) begin
      mismatched++; $display("FAIL midrst_tail: bytes %0d done %0d want 0 0", got_q.size(), done_cnt);
    end
    build(64, LMAC, SRC1, 16'h0800, 10);
    clear_mon();
    expect_payload(64);
    drive(0, 63);
    idle(3);
    compared++;
    if (first_diff() !== -1 || done_cnt !== 1 || last_good !== 1'b1 || remote_mac !== SRC1) begin
      mismatched++;
      $display("FAIL midrst_next: diff %0d done %0d good %0b mac %h want -1 1 1 %h",
               first_diff(), done_cnt, last_good, remote_mac, SRC1);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    build(64, LMAC, SRC1, 16'h0800, 11);
    clear_mon();
    expect_payload(64);
    drive(0, 63);
    idle(1);
    build(64, LMAC, SRC2, 16'h86DD, 12);
    expect_payload(64);
    rx_enable = 1'b1;
    rx_data = frm[0];
    @(posedge clock); #1;
    c0 = cyc;
    drive(1, 63);
    idle(3);
    compared++;
    if (done_cnt !== 2 || good_cnt !== 2) begin
      mismatched++; $display("FAIL b2b_status: done %0d good %0d want 2 2", done_cnt, good_cnt);
    end
    compared++;
    if (done_overlap !== 1) begin
      mismatched++; $display("FAIL b2b_overlap: got %0d want 1", done_overlap);
    end
    compared++;
    if (first_diff() !== -1 || got_q.size() !== 92) begin
      mismatched++; $display("FAIL b2b_data: diff %0d bytes %0d want -1 92", first_diff(), got_q.size());
    end
    // A synchronous consumer captures out_sof on the edge after it is registered.
    compared++;
    if (sof_cnt !== 2 || (sof_neg_cyc + 1 - c0) !== 19) begin
      mismatched++;
      $display("FAIL b2b_sof: count %0d latency %0d want 2 19", sof_cnt, sof_neg_cyc + 1 - c0);
    end
    compared++;
    if (remote_mac !== SRC2 || ethertype !== 16'h86DD) begin
      mismatched++; $display("FAIL b2b_hdr: got %h/%h want %h/86dd", remote_mac, ethertype, SRC2);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_unicast();
    test_broadcast();
    test_bad_crc();
    test_length();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
